multi_key_counter: RTL and testbench

Parametrised N-channel keypad tally for the DE-board demo designs. Each channel owns a push-button; a press (and, when held, auto-repeat) steps a per-channel BCD digit up or down by one, with wrap or saturate behaviour. A registered BCD sum of all channels is produced. Every digit is decoded for the 7-segment displays with selectable segment polarity.

---
 rtl/multi_key_counter_pkg.sv | 32 +++
 rtl/BCD_7Seg.sv | 26 ++
 rtl/multi_key_counter_key.sv | 67 ++++++
 rtl/multi_key_counter.sv | 127 ++++++++++++
 tb/tb_multi_key_counter.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/multi_key_counter_pkg.sv
// Shared types and constants for the multi-channel keypad tally: BCD digit type,
// direction encodings, active-low 7-segment patterns and binary-to-BCD helper.
package multi_key_counter_pkg;

  typedef logic [3:0] bcd_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  // Active-low patterns, bit 6 = g ... bit 0 = a.
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Values never exceed 99, so the quotient always fits one digit.
  function automatic logic [7:0] bin_to_bcd(input logic [6:0] v);
    logic [3:0] tens;
    tens = 4'(v / 7'd10);
    return {tens, 4'(v - 7'(tens) * 7'd10)};
  endfunction

endpackage

// File: rtl/BCD_7Seg.sv
// Single BCD digit to active-low 7-segment decoder; non-decimal codes blank the digit.
module BCD_7Seg
  import multi_key_counter_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/multi_key_counter_key.sv
// One push-button path: two-flop synchroniser, falling-edge press detector and
// auto-repeat hold counter; emits a one-cycle step pulse.
module key_step #(
  parameter int REPEAT_DELAY  = 25_000_000,
  parameter int REPEAT_PERIOD = 5_000_000
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic key_n,
  input  logic clear,
  output logic step
);

  localparam int  HOLD_MAX  = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int  HW        = $clog2(HOLD_MAX + 2);
  localparam bit  REP_EN    = (REPEAT_DELAY > 0);
  // A delay of one cycle coincides with the press itself, so the first
  // separate repeat comes one period later.
  localparam logic [HW-1:0] LOAD_FIRST  = (REPEAT_DELAY <= 1) ? HW'(REPEAT_PERIOD)
                                                              : HW'(REPEAT_DELAY - 1);
  localparam logic [HW-1:0] LOAD_PERIOD = HW'(REPEAT_PERIOD);

  logic          sync1_reg, sync2_reg, prev_reg;
  logic          live_reg, arm_reg;
  logic [HW-1:0] hold_reg, hold_next;
  logic          held, press, rep;

  // arm only sets once a genuine released sample has been seen, so a key
  // held through reset cannot produce a press on deassertion.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      sync1_reg <= 1'b1;
      sync2_reg <= 1'b1;
      prev_reg  <= 1'b1;
      live_reg  <= 1'b0;
      arm_reg   <= 1'b0;
      hold_reg  <= '0;
    end else begin
      sync1_reg <= key_n;
      sync2_reg <= sync1_reg;
      prev_reg  <= sync2_reg;
      live_reg  <= 1'b1;
      arm_reg   <= arm_reg | (live_reg & sync1_reg);
      hold_reg  <= hold_next;
    end
  end

  assign held  = ~sync2_reg;
  assign press = arm_reg & prev_reg & ~sync2_reg;
  assign rep   = REP_EN && held && (hold_reg == HW'(1));
  assign step  = press | rep;

  // hold_reg counts down to the next repeat; 0 means idle.
  always_comb begin
    hold_next = hold_reg;
    if (clear || !held) begin
      hold_next = '0;
    end else if (press) begin
      hold_next = REP_EN ? LOAD_FIRST : '0;
    end else if (rep) begin
      hold_next = LOAD_PERIOD;
    end else if (hold_reg > HW'(1)) begin
      hold_next = hold_reg - HW'(1);
    end
  end

endmodule

// File: rtl/multi_key_counter.sv
// N-channel keypad tally: per-channel BCD up/down counters with wrap or saturate,
// registered BCD sum of all channels, and 7-segment decoding of every digit.
module multi_key_counter
  import multi_key_counter_pkg::*;
#(
  parameter int N_CH          = 2,
  parameter int CNT_MAX       = 9,
  parameter int WRAP          = 1,
  parameter int REPEAT_DELAY  = 25_000_000,
  parameter int REPEAT_PERIOD = 5_000_000,
  parameter int SEG_AL        = 1
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic [N_CH-1:0]     key_n,
  input  logic [N_CH-1:0]     dir,
  input  logic                clear,
  output logic [4*N_CH-1:0]   cnt,
  output logic [N_CH-1:0]     wrap_p,
  output logic [7:0]          sum,
  output logic [7*N_CH-1:0]   hex_ch,
  output logic [13:0]         hex_sum
);

  localparam bcd_t TOP = bcd_t'(CNT_MAX);

  logic [N_CH-1:0] step;
  logic [6:0]      total;
  logic [7:0]      sum_reg;
  logic [6:0]      sum_seg [2];

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      bcd_t       cnt_reg, cnt_next;
      logic       wrap_reg, wrap_next;
      logic [6:0] seg;

      key_step #(
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_PERIOD(REPEAT_PERIOD)
      ) u_key (
        .CLOCK_50(CLOCK_50),
        .reset   (reset),
        .key_n   (key_n[gi]),
        .clear   (clear),
        .step    (step[gi])
      );

      always_comb begin
        cnt_next  = cnt_reg;
        wrap_next = 1'b0;
        if (clear) begin
          cnt_next = '0;
        end else if (step[gi]) begin
          if (dir_e'(dir[gi]) == DIR_UP) begin
            if (cnt_reg == TOP) begin
              if (WRAP != 0) begin
                cnt_next  = '0;
                wrap_next = 1'b1;
              end
            end else begin
              cnt_next = cnt_reg + 4'd1;
            end
          end else begin
            if (cnt_reg == '0) begin
              if (WRAP != 0) begin
                cnt_next  = TOP;
                wrap_next = 1'b1;
              end
            end else begin
              cnt_next = cnt_reg - 4'd1;
            end
          end
        end
      end

      always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
          cnt_reg  <= '0;
          wrap_reg <= 1'b0;
        end else begin
          cnt_reg  <= cnt_next;
          wrap_reg <= wrap_next;
        end
      end

      BCD_7Seg u_seg (
        .bcd(cnt_reg),
        .seg(seg)
      );

      assign cnt[4*gi +: 4]    = cnt_reg;
      assign wrap_p[gi]        = wrap_reg;
      assign hex_ch[7*gi +: 7] = (SEG_AL != 0) ? seg : ~seg;
    end
  endgenerate

  always_comb begin
    total = '0;
    for (int i = 0; i < N_CH; i++) begin
      total = total + 7'(cnt[4*i +: 4]);
    end
  end

  // Sum follows the counts by one cycle.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      sum_reg <= 8'h00;
    end else begin
      sum_reg <= bin_to_bcd(total);
    end
  end

  assign sum = sum_reg;

  generate
    for (gi = 0; gi < 2; gi++) begin : g_sum
      BCD_7Seg u_seg (
        .bcd(sum_reg[4*gi +: 4]),
        .seg(sum_seg[gi])
      );
      assign hex_sum[7*gi +: 7] = (SEG_AL != 0) ? sum_seg[gi] : ~sum_seg[gi];
    end
  endgenerate

endmodule

// File: tb/tb_multi_key_counter.sv
// Checks a wrapping, active-low instance and a saturating, active-high instance
// side by side against a sample-history model of the keypad tally.
module tb_multi_key_counter;

  localparam int D = 20;
  localparam int P = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] key_n = 2'b11;
  logic [1:0] dir = 2'b00;
  logic       clr = 1'b0;

  logic [7:0]  cnt_o     [2];
  logic [1:0]  wrap_o    [2];
  logic [7:0]  sum_o     [2];
  logic [13:0] hex_ch_o  [2];
  logic [13:0] hex_sum_o [2];

  int n_assert = 0;
  int n_fail   = 0;
  int w0_wraps = 0;
  int both_wraps = 0;
  int s_wraps  = 0;

  // model state: [inst][ch]; inst 0 wraps, inst 1 saturates
  int m_cnt  [2][2];
  int m_sum  [2];
  bit m_wrap [2][2];
  int hist   [2][3];   // key samples, newest first; 2 = "released" left by reset
  bit act    [2];
  int t_hold [2];
  bit stp    [2];

  always #10 clk = ~clk;

  multi_key_counter #(
    .N_CH(2), .CNT_MAX(9), .WRAP(1), .REPEAT_DELAY(D), .REPEAT_PERIOD(P), .SEG_AL(1)
  ) dut_w (
    .CLOCK_50(clk), .reset(rst), .key_n(key_n), .dir(dir), .clear(clr),
    .cnt(cnt_o[0]), .wrap_p(wrap_o[0]), .sum(sum_o[0]),
    .hex_ch(hex_ch_o[0]), .hex_sum(hex_sum_o[0])
  );

  multi_key_counter #(
    .N_CH(2), .CNT_MAX(9), .WRAP(0), .REPEAT_DELAY(D), .REPEAT_PERIOD(P), .SEG_AL(0)
  ) dut_s (
    .CLOCK_50(clk), .reset(rst), .key_n(key_n), .dir(dir), .clear(clr),
    .cnt(cnt_o[1]), .wrap_p(wrap_o[1]), .sum(sum_o[1]),
    .hex_ch(hex_ch_o[1]), .hex_sum(hex_sum_o[1])
  );

  task automatic chk(input string nm, input int got, input int want);
    n_assert++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, got, want, $time);
    end
  endtask

  function automatic logic [6:0] seg_exp(input int d, input int al);
    logic [6:0] s;
    case (d)
      0: s = 7'h40;  1: s = 7'h79;  2: s = 7'h24;  3: s = 7'h30;  4: s = 7'h19;
      5: s = 7'h12;  6: s = 7'h02;  7: s = 7'h78;  8: s = 7'h00;  9: s = 7'h10;
      default: s = 7'h7F;
    endcase
    return (al != 0) ? s : ~s;
  endfunction

  task model_reset();
    for (int w = 0; w < 2; w++) begin
      m_sum[w] = 0;
      for (int c = 0; c < 2; c++) begin
        m_cnt[w][c]  = 0;
        m_wrap[w][c] = 1'b0;
      end
    end
    for (int c = 0; c < 2; c++) begin
      for (int k = 0; k < 3; k++) hist[c][k] = 2;
      act[c]    = 1'b0;
      t_hold[c] = 0;
    end
  endtask

  task model_step();
    for (int c = 0; c < 2; c++) begin
      bit press, rep;
      press = (hist[c][1] == 0) && (hist[c][2] == 1);
      rep   = act[c] && (hist[c][1] == 0) && (t_hold[c] >= D - 1) &&
              (((t_hold[c] - (D - 1)) % P) == 0);
      stp[c] = press || rep;
    end
    for (int w = 0; w < 2; w++) begin
      m_sum[w] = m_cnt[w][0] + m_cnt[w][1];
      for (int c = 0; c < 2; c++) begin
        m_wrap[w][c] = 1'b0;
        if (clr) m_cnt[w][c] = 0;
        else if (stp[c]) begin
          if (dir[c] == 1'b0) begin
            if (m_cnt[w][c] == 9) begin
              if (w == 0) begin m_cnt[w][c] = 0; m_wrap[w][c] = 1'b1; end
            end else m_cnt[w][c]++;
          end else begin
            if (m_cnt[w][c] == 0) begin
              if (w == 0) begin m_cnt[w][c] = 9; m_wrap[w][c] = 1'b1; end
            end else m_cnt[w][c]--;
          end
        end
      end
    end
    for (int c = 0; c < 2; c++) begin
      if (clr) act[c] = 1'b0;
      hist[c][2] = hist[c][1];
      hist[c][1] = hist[c][0];
      hist[c][0] = int'(key_n[c]);
      if (hist[c][1] != 0) act[c] = 1'b0;
      else if (act[c]) t_hold[c]++;
      if (hist[c][1] == 0 && hist[c][2] == 1) begin
        act[c]    = 1'b1;
        t_hold[c] = 0;
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else model_step();
    end
  end

  // per-cycle compare against the model
  initial begin
    forever begin
      @(negedge clk);
      if (wrap_o[0][0]) w0_wraps++;
      if (wrap_o[0] == 2'b11) both_wraps++;
      if (wrap_o[1] != 2'b00) s_wraps++;
      for (int w = 0; w < 2; w++) begin
        int al;
        al = (w == 0) ? 1 : 0;
        chk($sformatf("cnt[%0d]", w), int'(cnt_o[w]), m_cnt[w][1] * 16 + m_cnt[w][0]);
        chk($sformatf("wrap_p[%0d]", w), int'(wrap_o[w]),
            int'(m_wrap[w][1]) * 2 + int'(m_wrap[w][0]));
        chk($sformatf("sum[%0d]", w), int'(sum_o[w]), (m_sum[w] / 10) * 16 + m_sum[w] % 10);
        chk($sformatf("hex_ch[%0d]", w), int'(hex_ch_o[w]),
            int'({seg_exp(m_cnt[w][1], al), seg_exp(m_cnt[w][0], al)}));
        chk($sformatf("hex_sum[%0d]", w), int'(hex_sum_o[w]),
            int'({seg_exp(m_sum[w] / 10, al), seg_exp(m_sum[w] % 10, al)}));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [1:0] m, input int hold);
    key_n = key_n & ~m;
    cyc(hold);
    key_n = key_n | m;
    cyc(4);
  endtask

  initial begin
    cyc(1);
    chk("rst_hex_ch_al", int'(hex_ch_o[0]), 'h2040);
    chk("rst_hex_ch_ah", int'(hex_ch_o[1]), 'h1FBF);
    cyc(2);
    rst = 1'b0;
    cyc(4);

    // ten up presses on channel 0
    w0_wraps = 0;
    for (int i = 0; i < 10; i++) press(2'b01, 2);
    cyc(2);
    chk("up10_cnt_wrap", int'(cnt_o[0][3:0]), 0);
    chk("up10_cnt_sat", int'(cnt_o[1][3:0]), 9);
    chk("up10_wraps", w0_wraps, 1);
    chk("up10_sum_wrap", int'(sum_o[0]), 'h00);

    // down from 0 on channel 1, then up twice
    dir = 2'b10;
    for (int i = 0; i < 3; i++) press(2'b10, 2);
    dir = 2'b00;
    for (int i = 0; i < 2; i++) press(2'b10, 2);
    cyc(2);
    chk("down_cnt_sat", int'(cnt_o[1]), 'h29);
    chk("down_sum_sat", int'(sum_o[1]), 'h11);
    chk("down_cnt_wrap", int'(cnt_o[0]), 'h90);

    // both channels at 9, simultaneous up step
    clr = 1'b1; cyc(1); clr = 1'b0;
    for (int i = 0; i < 9; i++) press(2'b11, 2);
    both_wraps = 0;
    press(2'b11, 2);
    cyc(2);
    chk("simul_cnt_sat", int'(cnt_o[1]), 'h99);
    chk("simul_sum_sat", int'(sum_o[1]), 'h18);
    chk("simul_cnt_wrap", int'(cnt_o[0]), 'h00);
    chk("simul_both_wrap", both_wraps, 1);

    // auto-repeat: 40 held samples give six increments
    clr = 1'b1; cyc(1); clr = 1'b0;
    press(2'b01, 40);
    cyc(30);
    chk("repeat_cnt_wrap", int'(cnt_o[0]), 'h06);
    chk("repeat_cnt_sat", int'(cnt_o[1]), 'h06);

    // clear on the same edge as a step that would wrap
    dir = 2'b10;
    key_n[1] = 1'b0;
    cyc(2);
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
    chk("clr_cnt", int'(cnt_o[0]), 'h00);
    chk("clr_wrap", int'(wrap_o[0]), 0);
    chk("clr_sum_lag", int'(sum_o[0]), 'h06);
    cyc(1);
    chk("clr_sum", int'(sum_o[0]), 'h00);
    key_n[1] = 1'b1;
    dir = 2'b00;
    cyc(4);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        int k;
        k = int'($urandom_range(0, 1));
        key_n[k] = ~key_n[k];
      end
      dir = 2'($urandom_range(0, 3));
      clr = ($urandom_range(0, 63) == 0);
      cyc(1);
    end
    clr = 1'b0;
    key_n = 2'b11;
    cyc(4);
    chk("sat_never_wraps", s_wraps, 0);

    // reset in the middle of a hold
    dir = 2'b00;
    press(2'b01, 2);
    key_n = 2'b10;
    cyc(8);
    #3 rst = 1'b1;
    cyc(1);
    chk("mid_rst_hex_al", int'(hex_ch_o[0]), 'h2040);
    chk("mid_rst_hexsum_al", int'(hex_sum_o[0]), 'h2040);
    chk("mid_rst_hex_ah", int'(hex_ch_o[1]), 'h1FBF);
    cyc(2);
    rst = 1'b0;
    cyc(30);
    chk("held_after_rst", int'(cnt_o[0]), 'h00);
    key_n = 2'b11;
    cyc(4);
    press(2'b01, 2);
    chk("press_after_rst", int'(cnt_o[0]), 'h01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
